// File: rtl/cc_pkg.sv
// Shared types and byte codes for the CipherCore UART command sequencer.
package cc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRxPay,
    StEngGo,
    StEngWait,
    StTxLoad,
    StTxHold,
    StTxDone,
    StTxErr
  } state_e;

  localparam logic [7:0] CMD_ENC = 8'hE0;
  localparam logic [7:0] CMD_DEC = 8'hD0;
  localparam logic [7:0] RSP_ERR = 8'hEE;

endpackage

// File: rtl/cc_timeout_ctr.sv
// Idle-cycle watchdog: counts enabled, non-cleared cycles and pulses expired on the MAX-th one.
module cc_timeout_ctr #(
  parameter int unsigned MAX = 30000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  // A clear in the same cycle suppresses expiry, so a late byte still wins.
  assign expired = enable && !clear && (cnt_q == W'(MAX - 1));

  // Count idle cycles; restart on clear, disable or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || !enable || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/cc_uart_sequencer.sv
// Command sequencer: assembles opcode+payload from the UART, runs one engine operation and
// streams the result back out byte by byte, MSB first.
module cc_uart_sequencer
  import cc_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 30000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     eng_start,
  output logic                     eng_mode,
  output logic [BLOCK_BYTES*8-1:0] eng_din,
  input  logic                     eng_done,
  input  logic [BLOCK_BYTES*8-1:0] eng_dout,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned DW = BLOCK_BYTES * 8;
  localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rx_sr_q, rx_sr_d;
  logic [DW-1:0]   tx_sr_q, tx_sr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            mode_q, mode_d;
  logic            tmo_expired;

  cc_timeout_ctr #(
    .MAX(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid),
    .enable (state_q == StRxPay),
    .expired(tmo_expired)
  );

  // Next-state, datapath updates and strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    tx_data_d = tx_data_q;
    mode_d    = mode_q;
    tx_start  = 1'b0;
    eng_start = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == CMD_ENC || rx_data == CMD_DEC) begin
            mode_d  = (rx_data == CMD_DEC);
            cnt_d   = '0;
            state_d = StRxPay;
          end else begin
            err       = 1'b1;
            tx_data_d = RSP_ERR;
            // Full count routes the single error byte from TX_HOLD straight to TX_DONE.
            cnt_d     = CW'(BLOCK_BYTES);
            state_d   = StTxErr;
          end
        end
      end
      StRxPay: begin
        if (rx_valid) begin
          rx_sr_d = {rx_sr_q[DW-9:0], rx_data};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(BLOCK_BYTES - 1)) state_d = StEngGo;
        end else if (tmo_expired) begin
          err     = 1'b1;
          rx_sr_d = '0;
          state_d = StIdle;
        end
      end
      StEngGo: begin
        eng_start = 1'b1;
        state_d   = StEngWait;
      end
      StEngWait: begin
        if (eng_done) begin
          tx_sr_d = eng_dout;
          cnt_d   = '0;
          state_d = StTxLoad;
        end
      end
      StTxLoad: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data_d = tx_sr_q[DW-1 -: 8];
          tx_sr_d   = {tx_sr_q[DW-9:0], 8'h00};
          cnt_d     = cnt_q + CW'(1);
          state_d   = StTxHold;
        end
      end
      StTxHold: begin
        state_d = (cnt_q == CW'(BLOCK_BYTES)) ? StTxDone : StTxLoad;
      end
      StTxDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      StTxErr: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StTxHold;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bytes arriving while a packet is in flight are dropped and flagged.
    if (rx_valid && state_q != StIdle && state_q != StRxPay) err = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      tx_data_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      tx_data_q <= tx_data_d;
      mode_q    <= mode_d;
    end
  end

  // The byte being launched is presented in its tx_start cycle, then held from the register.
  assign tx_data  = tx_start ? tx_data_d : tx_data_q;
  assign eng_mode = mode_q;
  assign eng_din  = rx_sr_q;
  assign busy     = (state_q != StIdle);

endmodule
